// File: rtl/thrd_cmd_issue.sv
// thrd_cmd_issue: queues thread commands, checks them against a spawn-parent table and issues kill/sleep/wake strobes.
module thrd_cmd_issue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [1:0]             cmd_op_i,
    input  logic [2:0]             cmd_src_i,
    input  logic [2:0]             cmd_dst_i,
    input  logic                   spawn_vld_i,
    input  logic [2:0]             spawn_parent_i,
    input  logic [2:0]             spawn_child_i,
    input  logic [7:0]             valid_thrd_i,
    input  logic [7:0]             run_thrd_i,
    input  logic                   stall_i,
    output logic                   kill_o,
    output logic                   slp_o,
    output logic                   wake_o,
    output logic [2:0]             act_thrd_o,
    output logic [2:0]             obj_thrd_o,
    output logic                   cmd_err_o,
    output logic [1:0]             err_code_o,
    output logic [$clog2(DEPTH):0] fifo_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, ISSUE = 2'd2;
    localparam logic [1:0] OP_KILL = 2'd0, OP_SLP = 2'd1, OP_WAKE = 2'd2, OP_RSV = 2'd3;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q;
    logic [2:0]    src_q, dst_q;
    logic [2:0]    par_q [8];
    logic [7:0]    pv_q;
    logic          err_q;
    logic [1:0]    code_q;
    logic          push, pop, perm, noop, issuing, kill_done;
    logic [1:0]    rej;

    assign cmd_ready_o = cnt_q != (AW+1)'(DEPTH);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = state_q == IDLE && cnt_q != '0;
    assign cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // a thread may never wake itself: it cannot be running the command if it is asleep
    assign perm        = !(op_q == OP_WAKE && dst_q == src_q) &&
                         (dst_q == src_q || (pv_q[dst_q] && par_q[dst_q] == src_q));
    assign rej         = op_q == OP_RSV ? 2'b11 : !valid_thrd_i[dst_q] ? 2'b10 : !perm ? 2'b01 : 2'b00;
    assign noop        = (op_q == OP_SLP && !run_thrd_i[dst_q]) || (op_q == OP_WAKE && run_thrd_i[dst_q]);
    assign issuing     = state_q == ISSUE;
    assign kill_done   = issuing && !stall_i && op_q == OP_KILL;

    always_comb begin
        state_d = state_q == IDLE  ? (pop ? CHECK : IDLE) :
                  state_q == CHECK ? ((rej != 2'b00 || noop) ? IDLE : ISSUE) :
                  (stall_i ? ISSUE : IDLE);
    end

    assign kill_o     = issuing && op_q == OP_KILL;
    assign slp_o      = issuing && op_q == OP_SLP;
    assign wake_o     = issuing && op_q == OP_WAKE;
    assign act_thrd_o = issuing ? src_q : 3'd0;
    assign obj_thrd_o = issuing ? dst_q : 3'd0;
    assign cmd_err_o  = err_q;
    assign err_code_o = code_q;
    assign fifo_cnt_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            src_q   <= 3'd0;
            dst_q   <= 3'd0;
            pv_q    <= '0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= state_q == CHECK && rej != 2'b00;
            code_q  <= state_q == CHECK ? rej : 2'b00;
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) begin
                {op_q, src_q, dst_q} <= mem_q[rd_q];
                rd_q                 <= rd_q + AW'(1);
            end
            // spawn is written last so it overrides an orphaning kill on the same entry
            for (int i = 0; i < 8; i++) begin
                if (kill_done && (dst_q == 3'(i) || par_q[i] == dst_q)) pv_q[i] <= 1'b0;
                if (spawn_vld_i && spawn_child_i == 3'(i)) pv_q[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_q] <= {cmd_op_i, cmd_src_i, cmd_dst_i};
        if (!rst && spawn_vld_i) par_q[spawn_child_i] <= spawn_parent_i;
    end
endmodule

// File: tb/tb_thrd_cmd_issue.sv
// tb_thrd_cmd_issue: directed scenario tests for thrd_cmd_issue with hand-computed expectations.
module tb_thrd_cmd_issue;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_src = 3'd0, cmd_dst = 3'd0;
    logic       spawn_vld = 1'b0;
    logic [2:0] spawn_parent = 3'd0, spawn_child = 3'd0;
    logic [7:0] valid_thrd = 8'h00, run_thrd = 8'h00;
    logic       stall = 1'b0;
    logic       kill, slp, wake, cmd_err;
    logic [2:0] act_thrd, obj_thrd;
    logic [1:0] err_code;
    logic [2:0] fifo_cnt;
    int         checks = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    thrd_cmd_issue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst),
        .spawn_vld_i(spawn_vld), .spawn_parent_i(spawn_parent), .spawn_child_i(spawn_child),
        .valid_thrd_i(valid_thrd), .run_thrd_i(run_thrd), .stall_i(stall),
        .kill_o(kill), .slp_o(slp), .wake_o(wake),
        .act_thrd_o(act_thrd), .obj_thrd_o(obj_thrd),
        .cmd_err_o(cmd_err), .err_code_o(err_code), .fifo_cnt_o(fifo_cnt)
    );

    task automatic push(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d);
        cmd_op = op; cmd_src = s; cmd_dst = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic spawn(input logic [2:0] p, input logic [2:0] c);
        spawn_parent = p; spawn_child = c; spawn_vld = 1'b1;
        @(negedge clk);
        spawn_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; spawn_vld = 1'b1; spawn_parent = 3'd0; spawn_child = 3'd2;
        repeat (2) @(negedge clk);
        checks++;
        if ({fifo_cnt, cmd_ready} !== {3'd0, 1'b1}) begin
            $display("FAIL reset_fifo: cnt/ready=%b exp 0001", {fifo_cnt, cmd_ready}); fails++;
        end
        checks++;
        if ({kill, slp, wake, act_thrd, obj_thrd, cmd_err, err_code} !== 12'd0) begin
            $display("FAIL reset_outs: got %b exp 0", {kill, slp, wake, act_thrd, obj_thrd, cmd_err, err_code}); fails++;
        end
        rst = 1'b0; cmd_valid = 1'b0; spawn_vld = 1'b0;
        @(negedge clk);
        checks++;
        if (fifo_cnt !== 3'd0) begin $display("FAIL reset_ignore_push: cnt=%0d exp 0", fifo_cnt); fails++; end
    endtask

    task automatic test_self_sleep;
        valid_thrd = 8'h01; run_thrd = 8'h01; stall = 1'b0;
        push(2'd1, 3'd0, 3'd0);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({kill, slp, wake, act_thrd, obj_thrd} !== (i == 3 ? 9'b010_000_000 : 9'd0)) begin
                $display("FAIL self_sleep_c%0d: got %b exp slp=%0d", i, {kill, slp, wake, act_thrd, obj_thrd}, i == 3); fails++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_child_kill_stall;
        int n = 0;
        spawn(3'd0, 3'd3);
        valid_thrd = 8'h09; run_thrd = 8'hFF; stall = 1'b1;
        push(2'd0, 3'd0, 3'd3);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (kill) begin
                n++; checks++;
                if ({act_thrd, obj_thrd} !== {3'd0, 3'd3}) begin
                    $display("FAIL kill_stall_fields: act/obj=%0d/%0d exp 0/3", act_thrd, obj_thrd); fails++;
                end
            end
            if (i == 4) stall = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (n != 5) begin $display("FAIL kill_stall_len: high %0d cycles exp 5", n); fails++; end
        push(2'd0, 3'd0, 3'd3);
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_err, err_code, kill, slp, wake} !== 6'b1_01_000) begin
            $display("FAIL rekill_err: got %b exp 101000", {cmd_err, err_code, kill, slp, wake}); fails++;
        end
        @(negedge clk);
        checks++;
        if (cmd_err !== 1'b0) begin $display("FAIL rekill_pulse: cmd_err=%b exp 0", cmd_err); fails++; end
    endtask

    task automatic test_rejects;
        logic [1:0] ops  [5] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd0};
        logic [2:0] srcs [5] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd0};
        logic [2:0] dsts [5] = '{3'd0, 3'd5, 3'd2, 3'd4, 3'd2};
        logic [7:0] vals [5] = '{8'hFF, 8'h0F, 8'hFF, 8'hFF, 8'hFF};
        logic [1:0] exps [5] = '{2'b11, 2'b10, 2'b01, 2'b01, 2'b01};
        run_thrd = 8'hFF; stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_thrd = vals[i];
            push(ops[i], srcs[i], dsts[i]);
            repeat (2) @(negedge clk);
            checks++;
            if ({cmd_err, err_code, kill, slp, wake} !== {1'b1, exps[i], 3'b000}) begin
                $display("FAIL reject_%0d: got %b exp %b", i, {cmd_err, err_code, kill, slp, wake}, {1'b1, exps[i], 3'b000}); fails++;
            end
            @(negedge clk);
            checks++;
            if ({cmd_err, kill, slp, wake} !== 4'd0) begin
                $display("FAIL reject_%0d_after: got %b exp 0000", i, {cmd_err, kill, slp, wake}); fails++;
            end
        end
    endtask

    task automatic test_kill_table;
        spawn(3'd0, 3'd1);
        spawn(3'd1, 3'd4);
        valid_thrd = 8'hFF; run_thrd = 8'hFF; stall = 1'b0;
        push(2'd0, 3'd0, 3'd1);
        repeat (2) @(negedge clk);
        checks++;
        if ({kill, act_thrd, obj_thrd} !== {1'b1, 3'd0, 3'd1}) begin
            $display("FAIL kill_child: got %b exp 1000001", {kill, act_thrd, obj_thrd}); fails++;
        end
        spawn_parent = 3'd5; spawn_child = 3'd1; spawn_vld = 1'b1;
        @(negedge clk);
        spawn_vld = 1'b0;
        push(2'd0, 3'd5, 3'd1);
        repeat (2) @(negedge clk);
        checks++;
        if ({kill, act_thrd, obj_thrd, cmd_err} !== {1'b1, 3'd5, 3'd1, 1'b0}) begin
            $display("FAIL spawn_wins: got %b exp 11010010", {kill, act_thrd, obj_thrd, cmd_err}); fails++;
        end
        @(negedge clk);
        push(2'd0, 3'd1, 3'd4);
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_err, err_code, kill} !== 4'b1_01_0) begin
            $display("FAIL orphan_kill: got %b exp 1010", {cmd_err, err_code, kill}); fails++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back_noop;
        spawn(3'd1, 3'd5);
        spawn(3'd1, 3'd6);
        valid_thrd = 8'hFF; run_thrd = 8'h20; stall = 1'b0;
        push(2'd2, 3'd1, 3'd5);
        push(2'd1, 3'd1, 3'd5);
        for (int i = 2; i <= 6; i++) begin
            checks++;
            if ({kill, slp, wake, act_thrd, obj_thrd, cmd_err} !== (i == 5 ? 10'b010_001_101_0 : 10'd0)) begin
                $display("FAIL noop_wake_c%0d: got %b", i, {kill, slp, wake, act_thrd, obj_thrd, cmd_err}); fails++;
            end
            @(negedge clk);
        end
        push(2'd1, 3'd1, 3'd6);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({kill, slp, wake, cmd_err} !== 4'd0) begin
                $display("FAIL noop_sleep_c%0d: got %b exp 0000", i, {kill, slp, wake, cmd_err}); fails++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fifo_full;
        int n = 0;
        valid_thrd = 8'hFF; run_thrd = 8'hFF; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin $display("FAIL full_ready_%0d: ready=%b exp 1", i, cmd_ready); fails++; end
            push(2'd1, 3'(i), 3'(i));
        end
        checks++;
        if ({fifo_cnt, cmd_ready} !== {3'd4, 1'b0}) begin
            $display("FAIL full_cnt: cnt=%0d ready=%b exp 4/0", fifo_cnt, cmd_ready); fails++;
        end
        cmd_op = 2'd1; cmd_src = 3'd5; cmd_dst = 3'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; stall = 1'b0;
        checks++;
        if (fifo_cnt !== 3'd4) begin $display("FAIL full_hold: cnt=%0d exp 4", fifo_cnt); fails++; end
        for (int i = 0; i < 25; i++) begin
            if (slp) begin
                checks++;
                if ({act_thrd, obj_thrd} !== {3'(n), 3'(n)}) begin
                    $display("FAIL full_order_%0d: act/obj=%0d/%0d exp %0d", n, act_thrd, obj_thrd, n); fails++;
                end
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 5 || fifo_cnt !== 3'd0) begin
            $display("FAIL full_drain: issued %0d cnt %0d exp 5 and 0", n, fifo_cnt); fails++;
        end
    endtask

    task automatic test_reset_in_issue;
        spawn(3'd2, 3'd6);
        valid_thrd = 8'hFF; run_thrd = 8'hFF; stall = 1'b1;
        push(2'd1, 3'd1, 3'd1);
        push(2'd1, 3'd2, 3'd2);
        push(2'd1, 3'd3, 3'd3);
        checks++;
        if ({slp, obj_thrd, fifo_cnt} !== {1'b1, 3'd1, 3'd2}) begin
            $display("FAIL pre_reset: got %b exp 10010010", {slp, obj_thrd, fifo_cnt}); fails++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({kill, slp, wake, fifo_cnt, cmd_ready} !== 7'b000_000_1) begin
            $display("FAIL reset_issue: got %b exp 0000001", {kill, slp, wake, fifo_cnt, cmd_ready}); fails++;
        end
        rst = 1'b0; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({kill, slp, wake} !== 3'd0) begin $display("FAIL reset_drop_%0d: strobes=%b exp 000", i, {kill, slp, wake}); fails++; end
            @(negedge clk);
        end
        push(2'd0, 3'd2, 3'd6);
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_err, err_code, kill} !== 4'b1_01_0) begin
            $display("FAIL reset_parent: got %b exp 1010", {cmd_err, err_code, kill}); fails++;
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_self_sleep;
        test_child_kill_stall;
        test_rejects;
        test_kill_table;
        test_back_to_back_noop;
        test_fifo_full;
        test_reset_in_issue;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/thrd_cmd_issue.md
THRD_CMD_ISSUE -- requirements
Module: thrd_cmd_issue

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of 2, at least 2).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 cmd_valid  in  1  thread command offered by pipeline.
REQ-005 cmd_ready  out  1  FIFO can accept a command.
REQ-006 cmd_op  in  2  command opcode: 00 kill, 01 sleep, 10 wake, 11 reserved.
REQ-007 cmd_src  in  3  thread issuing the command.
REQ-008 cmd_dst  in  3  target thread.
REQ-009 spawn_vld  in  1  one-cycle pulse: a thread was just created.
REQ-010 spawn_parent  in  3  creating thread.
REQ-011 spawn_child  in  3  created thread.
REQ-012 valid_thrd  in  8  per-thread valid status from the thread controller.
REQ-013 run_thrd  in  8  per-thread not-sleeping status from the thread controller.
REQ-014 stall  in  1  controller cannot take an action this cycle.
REQ-015 kill / slp / wake  out  1 each  command strobes to the thread controller.
REQ-016 act_thrd  out  3  source thread of the issued command.
REQ-017 obj_thrd  out  3  target thread of the issued command.
REQ-018 cmd_err  out  1  one-cycle pulse: a command was rejected.
REQ-019 err_code  out  2  rejection reason, valid while cmd_err is high: 01 not permitted, 10 target invalid, 11 reserved opcode.
REQ-020 fifo_cnt  out  $clog2(DEPTH)+1  number of queued commands.

Function
REQ-021 Push handshake: a command is pushed when cmd_valid and cmd_ready are both high; cmd_ready = (fifo_cnt != DEPTH), with no bypass when a pop happens in the same cycle.
REQ-022 Parent table: 8 entries, each holding a 3-bit parent and a parent-valid bit; spawn_vld writes entry[spawn_child] = {spawn_parent, 1}.
REQ-023 FSM states:
  - IDLE: if FIFO is non-empty, pop the head into the command register and go to CHECK; otherwise stay.
  - CHECK: evaluate the command for one cycle, then go to IDLE on a reject or to ISSUE otherwise.
  - ISSUE: drive the strobe; go to IDLE on the first cycle with stall low.
REQ-024 CHECK priority, first match wins:
  - opcode 11 -> code 11;
  - valid_thrd[dst]=0 -> code 10;
  - permission fails -> code 01.
  Permission = (dst==src) or (parent-valid[dst] and parent[dst]==src).
  Wake with dst==src is always code 01.
REQ-025 A reject raises cmd_err with err_code for exactly one cycle (the cycle after CHECK) and drives no strobe.
REQ-026 No-op drop: sleep with run_thrd[dst]=0, or wake with run_thrd[dst]=1, goes CHECK->IDLE with no strobe and no cmd_err.
REQ-027 In ISSUE, exactly one strobe matching opcode is high, act_thrd=src, obj_thrd=dst; strobes and thread fields hold steady across all stall cycles.
REQ-028 Outside ISSUE, all strobes are 0, and act_thrd/obj_thrd are 0.
REQ-029 Latency: a command pushed in cycle c with an empty FIFO and IDLE state has its strobe high in cycle c+3 when stall=0.
REQ-030 On the cycle a kill completes (ISSUE with stall low):
  - entry[dst] parent-valid is cleared;
  - every entry whose parent==dst has parent-valid cleared (orphaned).
REQ-031 If spawn_vld coincides with REQ-030 on the same entry, the spawn write wins.
REQ-032 FIFO pointers wrap modulo DEPTH; fifo_cnt tracks push minus pop exactly, including a simultaneous push and pop.
REQ-033 Throughput: at most one command per 3 cycles at the issue side; the FIFO absorbs bursts.

Reset
REQ-034 While rst is high at a clock edge:
  - FSM goes to IDLE;
  - FIFO is emptied (fifo_cnt=0, cmd_ready=1);
  - all parent-valid bits are cleared;
  - kill/slp/wake/cmd_err=0, err_code=0, act_thrd/obj_thrd=0.
REQ-035 Reset mid-ISSUE, including under stall, drops the pending command with no strobe in the following cycle; queued commands are discarded.
REQ-036 spawn_vld and cmd_valid are ignored in any cycle where rst is high.

Verification
REQ-037 Self sleep: valid_thrd=8'h01, run_thrd=8'h01; push op=01, src=0, dst=0 in cycle c -> slp=1, act_thrd=0, obj_thrd=0 in cycle c+3 only.
REQ-038 Child kill under stall: spawn 0->3, valid_thrd=8'h09; push kill src=0 dst=3; stall high 4 cycles during ISSUE -> kill high 5 cycles with obj_thrd=3; afterwards a kill src=0 dst=3 (valid_thrd[3] still 1) -> cmd_err, err_code=01.
REQ-039 Rejects:
  - op=11 -> err_code=11;
  - dst with valid_thrd bit 0 -> err_code=10;
  - src=1 targeting an unrelated thread 2 -> err_code=01;
  - wake src=dst=4 -> err_code=01.
  Each case gives one cmd_err pulse and no strobe.
REQ-040 FIFO full: stall held high, push DEPTH+1 commands -> cmd_ready falls when fifo_cnt=DEPTH; release stall -> all commands issue in order, fifo_cnt returns to 0.
REQ-041 No-op drops: wake of a running thread and sleep of a sleeping thread -> no strobe, no cmd_err, FSM back in IDLE 2 cycles after the pop.
REQ-042 Reset during ISSUE with stall=1 and 2 queued -> next cycle all strobes are 0, fifo_cnt=0, and an earlier child's kill is now rejected with err_code=01.
